trap_controller: RTL and testbench

//  Initiator side of the CSR interrupt/trap interface. Consumes csr_unit status (ip/ie/vec/status/epc),

---
 rtl/core_pkg.sv | 31 +++
 rtl/irq_synchronizer.sv | 23 ++
 rtl/trap_controller.sv | 168 ++++++++++++++++
 tb/tb_trap_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the trap controller and its IRQ synchronisers.
package core_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned CODE_W        = 5;
    localparam int unsigned IRQ_MSI       = 3;
    localparam int unsigned IRQ_MTI       = 7;
    localparam int unsigned IRQ_MEI       = 11;
    localparam int unsigned CAUSE_INT_BIT = 31;
    localparam int unsigned MSTATUS_MIE   = 3;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        TRAP,
        RET
    } trap_state_e;

    typedef enum logic [1:0] {
        EXC,
        IRQ,
        MRET
    } trap_kind_e;

    // Cause/epc pair captured when an event is accepted.
    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] epc;
    } trap_info_t;

endpackage

// File: rtl/irq_synchronizer.sv
// Flop chain bringing one asynchronous interrupt line into the clk domain.
module irq_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic sync
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], irq};
        end
    end

    assign sync = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_controller.sv
// Arbitrates exceptions, interrupts and mret; flushes the pipeline, then commits the
// trap/return to the CSR unit and redirects fetch.
module trap_controller
    import core_pkg::*;
#(
    parameter int unsigned     SYNC_STAGES = 2,
    parameter logic [XLEN-1:0] IRQ_MASK    = 32'h888
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              irq_soft_i,
    input  logic              irq_timer_i,
    input  logic              irq_ext_i,
    input  logic [XLEN-1:0]   ip_i,
    input  logic [XLEN-1:0]   ie_i,
    input  logic [XLEN-1:0]   vec_i,
    input  logic [XLEN-1:0]   status_i,
    input  logic [XLEN-1:0]   epc_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              exc_valid_i,
    input  logic [CODE_W-1:0] exc_cause_i,
    input  logic [XLEN-1:0]   exc_pc_i,
    input  logic              mret_i,
    input  logic              flush_ack_i,
    output logic [XLEN-1:0]   interrupt_src_o,
    output logic              flush_req_o,
    output logic              interrupt_valid_o,
    output logic [XLEN-1:0]   ecause_o,
    output logic [XLEN-1:0]   epc_o,
    output logic              ret_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    logic soft_sync, timer_sync, ext_sync;
    logic [XLEN-1:0] src_raw;

    irq_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_soft (
        .clk(clk_i), .rst_n(reset_ni), .irq(irq_soft_i), .sync(soft_sync)
    );
    irq_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_timer (
        .clk(clk_i), .rst_n(reset_ni), .irq(irq_timer_i), .sync(timer_sync)
    );
    irq_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
        .clk(clk_i), .rst_n(reset_ni), .irq(irq_ext_i), .sync(ext_sync)
    );

    always_comb begin
        src_raw          = '0;
        src_raw[IRQ_MSI] = soft_sync;
        src_raw[IRQ_MTI] = timer_sync;
        src_raw[IRQ_MEI] = ext_sync;
    end

    assign interrupt_src_o = src_raw & IRQ_MASK;

    // Pending interrupt and its code; MEI beats MSI beats MTI.
    logic [XLEN-1:0]   active;
    logic              pending;
    logic [CODE_W-1:0] irq_code;

    assign active  = ip_i & ie_i & IRQ_MASK;
    assign pending = status_i[MSTATUS_MIE] & (|active);

    always_comb begin
        irq_code = CODE_W'(IRQ_MTI);
        if (active[IRQ_MSI]) irq_code = CODE_W'(IRQ_MSI);
        if (active[IRQ_MEI]) irq_code = CODE_W'(IRQ_MEI);
    end

    logic unused_status;
    assign unused_status = ^{status_i[XLEN-1:MSTATUS_MIE+1], status_i[MSTATUS_MIE-1:0]};

    trap_state_e state_q, state_d;
    trap_kind_e  kind_q, kind_d;
    trap_info_t  info_q, info_d;

    // Trap target: direct base, or base + 4*code for vectored interrupts (modes 2/3 act direct).
    logic [XLEN-1:0] vec_base, vec_off, trap_pc;

    assign vec_base = {vec_i[XLEN-1:2], 2'b00};
    assign vec_off  = XLEN'({info_q.cause[CODE_W-1:0], 2'b00});
    assign trap_pc  = (vec_i[1:0] == 2'b01 && kind_q == IRQ) ? vec_base + vec_off : vec_base;

    logic            flush_d, valid_d, ret_d, rvalid_d;
    logic [XLEN-1:0] ecause_d, epc_d, rpc_d;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        info_d   = info_q;
        flush_d  = 1'b0;
        valid_d  = 1'b0;
        ret_d    = 1'b0;
        rvalid_d = 1'b0;
        ecause_d = '0;
        epc_d    = '0;
        rpc_d    = '0;

        case (state_q)
            IDLE: begin
                if (exc_valid_i) begin
                    kind_d       = EXC;
                    info_d.cause = XLEN'(exc_cause_i);
                    info_d.epc   = exc_pc_i;
                    state_d      = FLUSH;
                end else if (mret_i) begin
                    kind_d  = MRET;
                    state_d = FLUSH;
                end else if (pending) begin
                    kind_d                     = IRQ;
                    info_d.cause               = XLEN'(irq_code);
                    info_d.cause[CAUSE_INT_BIT] = 1'b1;
                    info_d.epc                 = pc_i;
                    state_d                    = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_ack_i) state_d = (kind_q == MRET) ? RET : TRAP;
            end
            TRAP:    state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Output flops follow the state being entered.
        flush_d = (state_d != IDLE);
        if (state_d == TRAP) begin
            valid_d  = 1'b1;
            ecause_d = info_q.cause;
            epc_d    = info_q.epc;
            rvalid_d = 1'b1;
            rpc_d    = trap_pc;
        end
        if (state_d == RET) begin
            ret_d    = 1'b1;
            rvalid_d = 1'b1;
            rpc_d    = epc_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q           <= IDLE;
            kind_q            <= EXC;
            info_q            <= '0;
            flush_req_o       <= 1'b0;
            interrupt_valid_o <= 1'b0;
            ecause_o          <= '0;
            epc_o             <= '0;
            ret_o             <= 1'b0;
            redirect_valid_o  <= 1'b0;
            redirect_pc_o     <= '0;
        end else begin
            state_q           <= state_d;
            kind_q            <= kind_d;
            info_q            <= info_d;
            flush_req_o       <= flush_d;
            interrupt_valid_o <= valid_d;
            ecause_o          <= ecause_d;
            epc_o             <= epc_d;
            ret_o             <= ret_d;
            redirect_valid_o  <= rvalid_d;
            redirect_pc_o     <= rpc_d;
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed scenarios plus randomized events checked against a behavioural model of the trap rules.
module tb_trap_controller;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        irq_soft_i, irq_timer_i, irq_ext_i;
    logic [31:0] ip_i, ie_i, vec_i, status_i, epc_i, pc_i, exc_pc_i;
    logic        exc_valid_i, mret_i, flush_ack_i;
    logic [4:0]  exc_cause_i;
    logic [31:0] interrupt_src_o, ecause_o, epc_o, redirect_pc_o;
    logic        flush_req_o, interrupt_valid_o, ret_o, redirect_valid_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    trap_controller #(.SYNC_STAGES(2), .IRQ_MASK(32'h888)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .irq_soft_i(irq_soft_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
        .ip_i(ip_i), .ie_i(ie_i), .vec_i(vec_i), .status_i(status_i), .epc_i(epc_i),
        .pc_i(pc_i), .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
        .exc_pc_i(exc_pc_i), .mret_i(mret_i), .flush_ack_i(flush_ack_i),
        .interrupt_src_o(interrupt_src_o), .flush_req_o(flush_req_o),
        .interrupt_valid_o(interrupt_valid_o), .ecause_o(ecause_o), .epc_o(epc_o),
        .ret_o(ret_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        irq_soft_i = 0; irq_timer_i = 0; irq_ext_i = 0;
        ip_i = 0; ie_i = 0; vec_i = 0; status_i = 0; epc_i = 0; pc_i = 0; exc_pc_i = 0;
        exc_valid_i = 0; mret_i = 0; flush_ack_i = 0; exc_cause_i = 0;
    endtask

    // Highest-priority implemented interrupt code: MEI(11) > MSI(3) > MTI(7).
    function automatic logic [4:0] model_code(input logic [31:0] act);
        int unsigned prio [3] = '{11, 3, 7};
        logic [4:0] code = 5'd0;
        for (int i = 2; i >= 0; i--) if (act[prio[i]]) code = 5'(prio[i]);
        return code;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] vec, input bit is_irq,
                                                 input logic [4:0] code);
        logic [31:0] base = vec & 32'hFFFF_FFFC;
        if (is_irq && vec[1:0] == 2'b01) return base + 32'(code) * 32'd4;
        return base;
    endfunction

    task automatic test_reset();
        reset_ni = 0;
        clear_inputs();
        step();
        total++;
        if ({flush_req_o, interrupt_valid_o, ret_o, redirect_valid_o} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000",
                            {flush_req_o, interrupt_valid_o, ret_o, redirect_valid_o});
        end
        total++;
        if ({ecause_o, epc_o, redirect_pc_o, interrupt_src_o} !== 128'd0) begin
            bad++; $display("FAIL reset_data: ecause=%h epc=%h rpc=%h src=%h want 0",
                            ecause_o, epc_o, redirect_pc_o, interrupt_src_o);
        end
        reset_ni = 1;
        step();
    endtask

    task automatic test_ext_irq();
        status_i = 32'h8; ie_i = 32'h800; ip_i = 32'h800; irq_ext_i = 1;
        vec_i = 32'h100; pc_i = 32'h200;
        step();
        total++;
        if (flush_req_o !== 1'b1 || interrupt_valid_o !== 1'b0) begin
            bad++; $display("FAIL ext_flush: flush=%b valid=%b want 1 0", flush_req_o, interrupt_valid_o);
        end
        flush_ack_i = 1;
        step();
        total++;
        if ({interrupt_valid_o, redirect_valid_o, flush_req_o} !== 3'b111 || ecause_o !== 32'h8000000B
            || epc_o !== 32'h200 || redirect_pc_o !== 32'h100) begin
            bad++; $display("FAIL ext_trap: v=%b rv=%b f=%b ecause=%h epc=%h rpc=%h want 1 1 1 8000000b 200 100",
                            interrupt_valid_o, redirect_valid_o, flush_req_o, ecause_o, epc_o, redirect_pc_o);
        end
        flush_ack_i = 0; status_i = 0;
        step();
        total++;
        if ({interrupt_valid_o, redirect_valid_o, flush_req_o} !== 3'b000) begin
            bad++; $display("FAIL ext_pulse_end: v=%b rv=%b f=%b want 000",
                            interrupt_valid_o, redirect_valid_o, flush_req_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_vectored();
        status_i = 32'h8; ie_i = 32'h80; ip_i = 32'h80; vec_i = 32'h101; pc_i = 32'h300;
        step();
        flush_ack_i = 1;
        step();
        total++;
        if (interrupt_valid_o !== 1'b1 || redirect_pc_o !== 32'h11C || ecause_o !== 32'h80000007) begin
            bad++; $display("FAIL vec_mti: v=%b rpc=%h ecause=%h want 1 11c 80000007",
                            interrupt_valid_o, redirect_pc_o, ecause_o);
        end
        flush_ack_i = 0; status_i = 0; ip_i = 0;
        step();
        exc_valid_i = 1; exc_cause_i = 5'd11; exc_pc_i = 32'h500;
        step();
        exc_valid_i = 0; flush_ack_i = 1;
        step();
        total++;
        if (interrupt_valid_o !== 1'b1 || redirect_pc_o !== 32'h100 || ecause_o !== 32'hB
            || epc_o !== 32'h500) begin
            bad++; $display("FAIL vec_ecall: v=%b rpc=%h ecause=%h epc=%h want 1 100 b 500",
                            interrupt_valid_o, redirect_pc_o, ecause_o, epc_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_priority();
        exc_valid_i = 1; exc_cause_i = 5'd2; exc_pc_i = 32'h700; mret_i = 1; epc_i = 32'h900;
        status_i = 32'h8; ie_i = 32'h800; ip_i = 32'h800; vec_i = 32'h40;
        step();
        exc_valid_i = 0; mret_i = 0; flush_ack_i = 1;
        step();
        total++;
        if (interrupt_valid_o !== 1'b1 || ret_o !== 1'b0 || ecause_o !== 32'h2 || epc_o !== 32'h700) begin
            bad++; $display("FAIL prio_exc: v=%b ret=%b ecause=%h epc=%h want 1 0 2 700",
                            interrupt_valid_o, ret_o, ecause_o, epc_o);
        end
        flush_ack_i = 0; status_i = 0; ip_i = 0;
        step();
        total++;
        if (ret_o !== 1'b0 || flush_req_o !== 1'b0) begin
            bad++; $display("FAIL prio_no_ret: ret=%b flush=%b want 0 0", ret_o, flush_req_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_mret();
        mret_i = 1; epc_i = 32'h400;
        step();
        mret_i = 0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (flush_req_o !== 1'b1 || ret_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
                bad++; $display("FAIL mret_hold%0d: flush=%b ret=%b rv=%b want 1 0 0",
                                i, flush_req_o, ret_o, redirect_valid_o);
            end
            step();
        end
        flush_ack_i = 1;
        step();
        total++;
        if (ret_o !== 1'b1 || redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h400
            || interrupt_valid_o !== 1'b0) begin
            bad++; $display("FAIL mret_commit: ret=%b rv=%b rpc=%h v=%b want 1 1 400 0",
                            ret_o, redirect_valid_o, redirect_pc_o, interrupt_valid_o);
        end
        flush_ack_i = 0;
        step();
        total++;
        if (ret_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
            bad++; $display("FAIL mret_pulse_end: ret=%b rv=%b want 0 0", ret_o, redirect_valid_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_masked();
        irq_soft_i = 1; irq_timer_i = 1; ip_i = 32'h88; ie_i = 32'hFFFF_FFFF; status_i = 0;
        step();
        total++;
        if (interrupt_src_o !== 32'h0) begin
            bad++; $display("FAIL sync_lat1: got %h want 0", interrupt_src_o);
        end
        step();
        total++;
        if (interrupt_src_o !== 32'h88) begin
            bad++; $display("FAIL sync_lat2: got %h want 88", interrupt_src_o);
        end
        status_i = 32'h8; ie_i = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (flush_req_o !== 1'b0 || interrupt_valid_o !== 1'b0) begin
                bad++; $display("FAIL masked_idle%0d: flush=%b v=%b want 0 0", i, flush_req_o, interrupt_valid_o);
            end
        end
        clear_inputs();
        step(); step(); step();
        total++;
        if (interrupt_src_o !== 32'h0) begin
            bad++; $display("FAIL sync_clear: got %h want 0", interrupt_src_o);
        end
    endtask

    task automatic test_reset_mid_flush();
        status_i = 32'h8; ie_i = 32'h800; ip_i = 32'h800; pc_i = 32'h600; vec_i = 32'h100;
        step();
        reset_ni = 0;
        #1;
        total++;
        if ({flush_req_o, interrupt_valid_o, ret_o, redirect_valid_o} !== 4'b0) begin
            bad++; $display("FAIL rst_async: got %b want 0000",
                            {flush_req_o, interrupt_valid_o, ret_o, redirect_valid_o});
        end
        step();
        reset_ni = 1;
        step();
        total++;
        if (flush_req_o !== 1'b1) begin
            bad++; $display("FAIL rst_retake_flush: flush=%b want 1", flush_req_o);
        end
        flush_ack_i = 1;
        step();
        total++;
        if (interrupt_valid_o !== 1'b1 || ecause_o !== 32'h8000000B || epc_o !== 32'h600) begin
            bad++; $display("FAIL rst_retake_trap: v=%b ecause=%h epc=%h want 1 8000000b 600",
                            interrupt_valid_o, ecause_o, epc_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        logic [31:0] cause_tab [3] = '{32'd2, 32'd3, 32'd11};
        for (int n = 0; n < 60; n++) begin
            int          kind;
            int          delay;
            logic [4:0]  code;
            logic [31:0] act, exp_cause, exp_epc, exp_pc;
            exc_valid_i = 1'($urandom_range(0, 3) == 0);
            mret_i      = 1'($urandom_range(0, 3) == 0);
            exc_cause_i = 5'(cause_tab[$urandom_range(0, 2)]);
            ip_i = $urandom & 32'hFFF;  ie_i = $urandom & 32'hFFF;
            status_i = $urandom;         vec_i = $urandom;
            pc_i = $urandom;  exc_pc_i = $urandom;  epc_i = $urandom;
            act  = ip_i & ie_i & 32'h888;
            code = model_code(act);
            kind = 0; exp_cause = 0; exp_epc = 0; exp_pc = 0;
            if (exc_valid_i) begin
                kind = 1; exp_cause = 32'(exc_cause_i); exp_epc = exc_pc_i;
                exp_pc = model_target(vec_i, 0, 5'd0);
            end else if (mret_i) begin
                kind = 2; exp_pc = epc_i;
            end else if (status_i[3] && act != 0) begin
                kind = 3; exp_cause = 32'h8000_0000 | 32'(code); exp_epc = pc_i;
                exp_pc = model_target(vec_i, 1, code);
            end
            step();
            exc_valid_i = 0; mret_i = 0;
            total++;
            if (flush_req_o !== (kind != 0)) begin
                bad++; $display("FAIL rnd%0d_flush: got %b want %b", n, flush_req_o, kind != 0);
            end
            if (kind != 0) begin
                delay = $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 1) ip_i = 0;
                for (int d = 0; d < delay; d++) step();
                flush_ack_i = 1;
                step();
                total++;
                if (interrupt_valid_o !== (kind != 2) || ret_o !== (kind == 2)
                    || redirect_valid_o !== 1'b1 || redirect_pc_o !== exp_pc) begin
                    bad++; $display("FAIL rnd%0d_commit: v=%b ret=%b rv=%b rpc=%h want %b %b 1 %h", n,
                                    interrupt_valid_o, ret_o, redirect_valid_o, redirect_pc_o,
                                    kind != 2, kind == 2, exp_pc);
                end
                if (kind != 2) begin
                    total++;
                    if (ecause_o !== exp_cause || epc_o !== exp_epc) begin
                        bad++; $display("FAIL rnd%0d_cause: ecause=%h epc=%h want %h %h", n,
                                        ecause_o, epc_o, exp_cause, exp_epc);
                    end
                end
                flush_ack_i = 0; status_i = 0;
                step();
                total++;
                if ({flush_req_o, interrupt_valid_o, ret_o, redirect_valid_o} !== 4'b0) begin
                    bad++; $display("FAIL rnd%0d_idle: got %b want 0000", n,
                                    {flush_req_o, interrupt_valid_o, ret_o, redirect_valid_o});
                end
            end
            clear_inputs();
        end
    endtask

    initial begin
        test_reset();
        test_ext_irq();
        test_vectored();
        test_priority();
        test_mret();
        test_masked();
        test_reset_mid_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
